adc_scan_scheduler: RTL and testbench

//  Sequences periodic conversions on the I2C ADC controller for the scope front end.

---
 rtl/adc_scan_scheduler.sv | 160 ++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler.sv
// Periodic round-robin scan of the ADC controller channels: one conversion per
// sample-period tick, results forwarded as channel-tagged samples on a valid/ready stream.
module adc_scan_scheduler #(
  parameter int DATA_W   = 12,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 4096,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [3:0]          ch_mask,
  input  logic [PERIOD_W-1:0] sample_period,
  output logic                adc_start,
  output logic [1:0]          adc_channel,
  input  logic                adc_done,
  input  logic [DATA_W-1:0]   adc_data,
  input  logic                adc_nack,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [DATA_W-1:0]   sample_data,
  output logic [1:0]          sample_ch,
  output logic                sample_err,
  output logic                busy,
  output logic [CNT_W-1:0]    overrun_cnt,
  output logic [CNT_W-1:0]    timeout_cnt
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ISSUE,
    WAIT_DONE,
    EMIT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PERIOD_W-1:0] timer;
  logic                tick;
  logic [1:0]          last_ch;
  logic [1:0]          nxt_ch;
  logic                mask_any;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timed_out;
  logic                in_transfer;

  assign mask_any    = |ch_mask;
  assign tick        = (state != IDLE) && (timer == '0);
  assign timed_out   = (state == WAIT_DONE) && (wait_cnt == WAIT_LAST);
  assign in_transfer = (state == ISSUE) || (state == WAIT_DONE) || (state == EMIT);

  // Round-robin pick: first enabled channel after last_ch; the fourth candidate
  // is last_ch itself, so a single-channel mask keeps re-selecting that channel.
  always_comb begin
    logic [1:0] cand;
    logic       found;
    nxt_ch = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_ch + 2'(i);
      if (!found && ch_mask[cand]) begin
        nxt_ch = cand;
        found  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (enable && mask_any) state_nxt = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable || !mask_any) state_nxt = IDLE;
        else if (tick)            state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = mask_any ? WAIT_DONE : IDLE;
      end
      WAIT_DONE: begin
        if (adc_done)       state_nxt = EMIT;
        else if (timed_out) state_nxt = enable ? WAIT_TICK : IDLE;
      end
      EMIT: begin
        if (sample_ready) state_nxt = enable ? WAIT_TICK : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    adc_start    = (state == ISSUE) && mask_any;
    sample_valid = (state == EMIT);
    busy         = (state != IDLE);
    adc_channel  = '0;
    if (state == ISSUE)          adc_channel = nxt_ch;
    else if (state == WAIT_DONE) adc_channel = last_ch;
  end

  // Period timer: frozen while idle, loaded on leaving IDLE, free-running otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer <= '0;
    end else if (state == IDLE) begin
      timer <= (state_nxt == WAIT_TICK) ? sample_period : '0;
    end else if (tick) begin
      timer <= sample_period;
    end else begin
      timer <= timer - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      last_ch  <= 2'd3;
    end else begin
      wait_cnt <= (state == WAIT_DONE) ? wait_cnt + 1'b1 : '0;
      if (state == ISSUE && mask_any) last_ch <= nxt_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sample_data <= '0;
      sample_ch   <= '0;
      sample_err  <= 1'b0;
    end else if (state == WAIT_DONE && adc_done) begin
      sample_data <= adc_data;
      sample_ch   <= last_ch;
      sample_err  <= adc_nack;
    end
  end

  // Error counters saturate at all-ones; a done arriving on the timeout cycle wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      if (tick && in_transfer && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
      if (timed_out && !adc_done && timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler: scan order, pacing, overrun/timeout
// counters, output hold under back-pressure and reset mid-transfer.
module tb_adc_scan_scheduler;

  localparam int DATA_W   = 12;
  localparam int PERIOD_W = 16;
  localparam int TIMEOUT  = 16;
  localparam int CNT_W    = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                enable = 1'b0;
  logic [3:0]          ch_mask = '0;
  logic [PERIOD_W-1:0] sample_period = '0;
  logic                adc_start;
  logic [1:0]          adc_channel;
  logic                adc_done = 1'b0;
  logic [DATA_W-1:0]   adc_data = '0;
  logic                adc_nack = 1'b0;
  logic                sample_valid;
  logic                sample_ready = 1'b0;
  logic [DATA_W-1:0]   sample_data;
  logic [1:0]          sample_ch;
  logic                sample_err;
  logic                busy;
  logic [CNT_W-1:0]    overrun_cnt;
  logic [CNT_W-1:0]    timeout_cnt;

  adc_scan_scheduler #(
    .DATA_W(DATA_W), .PERIOD_W(PERIOD_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .sample_period(sample_period), .adc_start(adc_start), .adc_channel(adc_channel),
    .adc_done(adc_done), .adc_data(adc_data), .adc_nack(adc_nack),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .sample_ch(sample_ch), .sample_err(sample_err), .busy(busy),
    .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ADC controller model: answers each start after resp_delay cycles.
  logic              resp_en    = 1'b0;
  int                resp_delay = 1;
  logic [DATA_W-1:0] resp_data  = '0;
  logic              resp_nack  = 1'b0;

  always begin
    @(negedge clk);
    if (adc_start && resp_en) begin
      repeat (resp_delay) @(negedge clk);
      adc_data = resp_data;
      adc_nack = resp_nack;
      adc_done = 1'b1;
      @(negedge clk);
      adc_done = 1'b0;
    end
  end

  // Stream sink monitor: logs every accepted sample.
  int                n_samp = 0;
  logic [1:0]        samp_ch_q[$];
  logic [DATA_W-1:0] samp_data_q[$];
  logic              samp_err_q[$];
  int                samp_cyc_q[$];

  always begin
    @(negedge clk);
    #1;
    if (sample_valid && sample_ready) begin
      n_samp++;
      samp_ch_q.push_back(sample_ch);
      samp_data_q.push_back(sample_data);
      samp_err_q.push_back(sample_err);
      samp_cyc_q.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    n_samp = 0;
    samp_ch_q.delete();
    samp_data_q.delete();
    samp_err_q.delete();
    samp_cyc_q.delete();
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst    = 1'b0;
    step(2);
    rst    = 1'b1;
    step(1);
    clear_log();
  endtask

  // Returns on the negedge of the cycle that shows adc_start; at_cyc=-1 on budget expiry.
  task automatic wait_start(input int budget, output int at_cyc, output logic [1:0] ch);
    at_cyc = -1;
    ch     = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (adc_start) begin
        at_cyc = cyc;
        ch     = adc_channel;
        break;
      end
    end
  endtask

  int         e0;
  int         sc;
  int         prev;
  int         n_start;
  int         n_busy;
  int         hold_bad;
  logic [1:0] ch;
  logic [1:0] exp_ch1 [4];

  initial begin
    exp_ch1 = '{2'd0, 2'd1, 2'd3, 2'd0};

    // Reset state
    step(3);
    check("rst_busy", busy, 0);
    check("rst_start", adc_start, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_chan", adc_channel, 0);
    check("rst_data", sample_data, 0);
    check("rst_ovr", overrun_cnt, 0);
    check("rst_tmo", timeout_cnt, 0);
    rst = 1'b1;
    step(1);

    // 1: mask 1011, period 9, done 5 cycles after start
    ch_mask = 4'b1011; sample_period = 9; resp_delay = 5; resp_data = 12'h123;
    resp_nack = 1'b0; resp_en = 1'b1; sample_ready = 1'b1;
    e0 = cyc; enable = 1'b1;
    prev = e0;
    for (int k = 0; k < 4; k++) begin
      wait_start(30, sc, ch);
      check($sformatf("t1_gap%0d", k), sc - prev, (k == 0) ? 11 : 10);
      check($sformatf("t1_ch%0d", k), ch, exp_ch1[k]);
      prev = sc;
    end
    enable = 1'b0;
    step(10);
    check("t1_idle", busy, 0);
    check("t1_nsamp", n_samp, 4);
    if (n_samp == 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("t1_sch%0d", k), samp_ch_q[k], exp_ch1[k]);
      check("t1_data", samp_data_q[0], 12'h123);
      check("t1_err", samp_err_q[0], 0);
      check("t1_lat", samp_cyc_q[0] - e0, 17);
    end
    check("t1_ovr", overrun_cnt, 0);

    // 2: empty mask never issues
    do_reset();
    ch_mask = 4'b0000; enable = 1'b1;
    n_start = 0; n_busy = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (adc_start) n_start++;
      if (busy) n_busy++;
    end
    check("t2_starts", n_start, 0);
    check("t2_busy", n_busy, 0);

    // 3: period 0 -> every transfer cycle is an overrun; counter saturates
    do_reset();
    ch_mask = 4'b0001; sample_period = 0; resp_delay = 8; resp_en = 1'b1;
    enable = 1'b1;
    wait_start(10, sc, ch);
    check("t3_ch", ch, 0);
    step(10);
    check("t3_ovr10", overrun_cnt, 10);
    step(15);
    check("t3_ovr_sat", overrun_cnt, 15);
    enable = 1'b0;
    step(20);
    check("t3_idle", busy, 0);
    check("t3_tmo", timeout_cnt, 0);

    // 4: no done -> timeout after TIMEOUT cycles, channel still advances
    do_reset();
    ch_mask = 4'b0011; sample_period = 29; resp_en = 1'b0;
    e0 = cyc; enable = 1'b1;
    wait_start(40, sc, ch);
    check("t4_first", sc - e0, 31);
    check("t4_ch0", ch, 0);
    step(16);
    check("t4_tmo0", timeout_cnt, 0);
    step(1);
    check("t4_tmo1", timeout_cnt, 1);
    check("t4_busy", busy, 1);
    prev = sc;
    wait_start(40, sc, ch);
    check("t4_gap", sc - prev, 30);
    check("t4_ch1", ch, 1);
    enable = 1'b0;
    step(20);
    check("t4_idle", busy, 0);
    check("t4_tmo2", timeout_cnt, 2);
    check("t4_nsamp", n_samp, 0);
    check("t4_ovr", overrun_cnt, 0);

    // 5: back-pressure for 50 cycles, NACKed sample of 12'hABC on ch 2
    do_reset();
    ch_mask = 4'b0100; sample_period = 9; resp_delay = 5; resp_data = 12'hABC;
    resp_nack = 1'b1; resp_en = 1'b1; sample_ready = 1'b0;
    enable = 1'b1;
    wait_start(20, sc, ch);
    check("t5_ch", ch, 2);
    for (int i = 0; i < 20 && !sample_valid; i++) step(1);
    check("t5_valid", sample_valid, 1);
    hold_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(sample_valid && sample_data == 12'hABC && sample_ch == 2'd2 && sample_err)) hold_bad++;
      step(1);
    end
    check("t5_hold", hold_bad, 0);
    sample_ready = 1'b1;
    step(1);
    enable = 1'b0;
    check("t5_drop", sample_valid, 0);
    check("t5_nsamp", n_samp, 1);
    check("t5_ovr", overrun_cnt, 5);
    if (n_samp == 1) check("t5_sdata", samp_data_q[0], 12'hABC);
    step(5);

    // 6: reset while waiting for done; the late done is lost
    do_reset();
    ch_mask = 4'b1111; sample_period = 4; resp_delay = 2; resp_data = 12'h5A5;
    resp_nack = 1'b1; resp_en = 1'b1; sample_ready = 1'b1;
    enable = 1'b1;
    wait_start(20, sc, ch);
    check("t6_ch0", ch, 0);
    wait_start(20, sc, ch);
    check("t6_ch1", ch, 1);
    step(1);
    check("t6_wait", busy, 1);
    rst = 1'b0;
    step(1);
    check("t6_busy", busy, 0);
    check("t6_valid", sample_valid, 0);
    check("t6_start", adc_start, 0);
    check("t6_data", sample_data, 0);
    check("t6_err", sample_err, 0);
    check("t6_chan", adc_channel, 0);
    step(1);
    rst = 1'b1;
    wait_start(20, sc, ch);
    check("t6_restart_ch", ch, 0);
    check("t6_nsamp", n_samp, 1);
    enable = 1'b0;
    step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
